// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with a per-register busy scoreboard.
// Same-cycle write-back is bypassed to both read ports and hides busy.

module reg_file_sb_entry #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_hit_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic            set_i,
    input  logic            clr_i,
    output logic [XLEN-1:0] data_o,
    output logic            busy_o
);
    logic [XLEN-1:0] data_q;
    logic            busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            if (wr_hit_i) data_q <= wr_data_i;
            // A new producer issuing on the same edge outranks the write-back clear.
            if (set_i)      busy_q <= 1'b1;
            else if (clr_i) busy_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;
endmodule

module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic [AW:0]     busy_count
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic                       wr_ok;
    logic                       iss_ok;

    assign wr_ok  = wr_en && (wr_addr != '0);
    assign iss_ok = issue_en && (issue_rd != '0);

    // x0 is hardwired: no storage, never busy.
    for (genvar i = 0; i < NREGS; i++) begin : g_ent
        if (i == 0) begin : g_zero
            assign regs[i] = '0;
            assign busy[i] = 1'b0;
        end else begin : g_reg
            reg_file_sb_entry #(.XLEN(XLEN)) u_ent (
                .clk       (clk),
                .rst       (rst),
                .wr_hit_i  (wr_ok && (wr_addr == AW'(i))),
                .wr_data_i (wr_data),
                .set_i     (iss_ok && (issue_rd == AW'(i))),
                .clr_i     (wr_en && (wr_addr == AW'(i))),
                .data_o    (regs[i]),
                .busy_o    (busy[i])
            );
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (wr_ok && (wr_addr == rs1_addr)) rs1_data = wr_data;
        if (wr_ok && (wr_addr == rs2_addr)) rs2_data = wr_data;
    end

    assign rs1_busy = busy[rs1_addr] && !(wr_en && (wr_addr == rs1_addr));
    assign rs2_busy = busy[rs2_addr] && !(wr_en && (wr_addr == rs2_addr));

    // Population count maintained incrementally from the actual bit transitions.
    logic        cnt_inc;
    logic        cnt_dec;
    logic [AW:0] cnt_q;
    logic [AW:0] cnt_d;

    assign cnt_inc = iss_ok && !busy[issue_rd];
    assign cnt_dec = wr_ok && busy[wr_addr] && !(iss_ok && (issue_rd == wr_addr));

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + (AW+1)'(1);
        else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign busy_count = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, scoreboard
// sweep, and randomized traffic against an array-based reference model.

module tb_reg_file_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            issue_en;
    logic [AW-1:0]   issue_rd;
    logic [AW:0]     busy_count;

    int n_chk;
    int n_fail;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .busy_count (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0;
    endtask

    typedef struct {
        logic            rst;
        logic            wr_en;
        logic [AW-1:0]   wr_addr;
        logic [XLEN-1:0] wr_data;
        logic            issue_en;
        logic [AW-1:0]   issue_rd;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [XLEN-1:0] e1d;
        logic [XLEN-1:0] e2d;
        logic            e1b;
        logic            e2b;
        logic [AW:0]     ecnt;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    // Reference model state
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < NREGS; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
        if (wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
        return (a == 0) ? '0 : m_regs[a];
    endfunction

    task automatic m_edge();
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin m_regs[k] = '0; m_busy[k] = 0; end
        end else begin
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (wr_en) m_busy[wr_addr] = 0;
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        // rst wr wa wd iss rd rs1 rs2 | e1d e2d e1b e2b cnt
        vecs[0]  = '{0,0,0,32'h0,       0,0, 0,0, 32'h0,       32'h0,       0,0,0};
        vecs[1]  = '{0,1,5,32'hDEADBEEF,0,0, 5,1, 32'hDEADBEEF,32'h0,       0,0,0};
        vecs[2]  = '{0,0,0,32'h0,       0,0, 5,5, 32'hDEADBEEF,32'hDEADBEEF,0,0,0};
        vecs[3]  = '{0,1,7,32'h1234,    0,0, 7,5, 32'h1234,    32'hDEADBEEF,0,0,0};
        vecs[4]  = '{0,1,0,32'hFFFFFFFF,1,0, 0,7, 32'h0,       32'h1234,    0,0,0};
        vecs[5]  = '{0,0,0,32'h0,       0,0, 0,0, 32'h0,       32'h0,       0,0,0};
        vecs[6]  = '{0,0,0,32'h0,       1,3, 3,0, 32'h0,       32'h0,       0,0,0};
        vecs[7]  = '{0,0,0,32'h0,       1,4, 3,4, 32'h0,       32'h0,       1,0,1};
        vecs[8]  = '{0,1,3,32'hAA,      0,0, 3,4, 32'hAA,      32'h0,       0,1,2};
        vecs[9]  = '{0,1,4,32'hBB,      1,4, 3,4, 32'hAA,      32'hBB,      0,0,1};
        vecs[10] = '{0,0,0,32'h0,       0,0, 4,3, 32'hBB,      32'hAA,      1,0,1};
        vecs[11] = '{0,1,9,32'h55,      1,9, 9,0, 32'h55,      32'h0,       0,0,1};
        vecs[12] = '{0,0,0,32'h0,       1,10,9,4, 32'h55,      32'hBB,      1,1,2};
        vecs[13] = '{1,1,12,32'h77,     1,12,12,9,32'h77,      32'h55,      0,1,3};
        vecs[14] = '{0,0,0,32'h0,       0,0, 9,4, 32'h0,       32'h0,       0,0,0};
        vecs[15] = '{0,0,0,32'h0,       0,0, 12,10,32'h0,      32'h0,       0,0,0};

        rst = 1'b1; rs1_addr = '0; rs2_addr = '0;
        idle();
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_count", XLEN'(busy_count), 0);

        for (int v = 0; v < NV; v++) begin
            rst = vecs[v].rst;
            wr_en = vecs[v].wr_en; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
            issue_en = vecs[v].issue_en; issue_rd = vecs[v].issue_rd;
            rs1_addr = vecs[v].rs1; rs2_addr = vecs[v].rs2;
            #1;
            check($sformatf("vec%0d_rs1_data", v), rs1_data, vecs[v].e1d);
            check($sformatf("vec%0d_rs2_data", v), rs2_data, vecs[v].e2d);
            check($sformatf("vec%0d_rs1_busy", v), XLEN'(rs1_busy), XLEN'(vecs[v].e1b));
            check($sformatf("vec%0d_rs2_busy", v), XLEN'(rs2_busy), XLEN'(vecs[v].e2b));
            check($sformatf("vec%0d_count", v), XLEN'(busy_count), XLEN'(vecs[v].ecnt));
            tick();
            rst = 1'b0;
        end
        idle();

        // Fill every architectural register's busy bit, then drain.
        for (int i = 1; i < NREGS; i++) begin
            issue_en = 1'b1; issue_rd = AW'(i);
            #1;
            check($sformatf("fill_count_%0d", i), XLEN'(busy_count), XLEN'(i - 1));
            tick();
        end
        idle();
        #1;
        check("fill_full", XLEN'(busy_count), NREGS - 1);
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = XLEN'(i * 3);
            rs1_addr = AW'(i); rs2_addr = AW'(i == NREGS - 1 ? 1 : i + 1);
            #1;
            check($sformatf("drain_count_%0d", i), XLEN'(busy_count), XLEN'(NREGS - i));
            check($sformatf("drain_hide_%0d", i), XLEN'(rs1_busy), 0);
            if (i < NREGS - 1) check($sformatf("drain_next_busy_%0d", i), XLEN'(rs2_busy), 1);
            tick();
        end
        idle();
        #1;
        check("drain_empty", XLEN'(busy_count), 0);

        // Randomized traffic against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NREGS; k++) begin m_regs[k] = '0; m_busy[k] = 0; end
        for (int c = 0; c < 2000; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = AW'($urandom_range(0, NREGS - 1));
            wr_data  = $urandom;
            issue_en = $urandom_range(0, 2) != 0;
            issue_rd = AW'($urandom_range(0, NREGS - 1));
            rs1_addr = AW'($urandom_range(0, NREGS - 1));
            rs2_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
            #1;
            check("rnd_rs1_data", rs1_data, m_read(rs1_addr));
            check("rnd_rs2_data", rs2_data, m_read(rs2_addr));
            check("rnd_rs1_busy", XLEN'(rs1_busy),
                  XLEN'(m_busy[rs1_addr] && !(wr_en && wr_addr == rs1_addr)));
            check("rnd_rs2_busy", XLEN'(rs2_busy),
                  XLEN'(m_busy[rs2_addr] && !(wr_en && wr_addr == rs2_addr)));
            check("rnd_count", XLEN'(busy_count), XLEN'(m_count()));
            m_edge();
            tick();
        end
        rst = 1'b0;
        idle();
        #1;
        check("rnd_final_count", XLEN'(busy_count), XLEN'(m_count()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
- REQ-001: Parameter XLEN, default 32, register data width in bits.
- REQ-002: Parameter NREGS, default 32, number of architectural registers; a power of two, at least 2.
- REQ-003: Derived constant AW = log2(NREGS), the address width.
- REQ-004: Port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-005: Port rst, input, 1, reset; synchronous and active-high.
- REQ-006: Port rs1_addr, input, AW, read port 1 address.
- REQ-007: Port rs2_addr, input, AW, read port 2 address.
- REQ-008: Port rs1_data, output, XLEN, read port 1 data (combinational).
- REQ-009: Port rs2_data, output, XLEN, read port 2 data (combinational).
- REQ-010: Port rs1_busy, output, 1, the register at rs1_addr has a pending producer.
- REQ-011: Port rs2_busy, output, 1, the register at rs2_addr has a pending producer.
- REQ-012: Port wr_en, input, 1, write-back request.
- REQ-013: Port wr_addr, input, AW, write-back destination.
- REQ-014: Port wr_data, input, XLEN, write-back data.
- REQ-015: Port issue_en, input, 1, an instruction issues and claims a destination.
- REQ-016: Port issue_rd, input, AW, the destination claimed by the issuing instruction.
- REQ-017: Port busy_count, output, AW+1, number of registers currently marked busy.

Function
- REQ-018: Register 0 SHALL always read 0; writes to it and issues to it are ignored (its busy bit stays 0).
- REQ-019: On a clk edge with wr_en=1 and wr_addr!=0, regs[wr_addr] SHALL take wr_data; the written value is visible from the next cycle.
- REQ-020: Bypass: if wr_en=1, wr_addr!=0 and wr_addr==rsN_addr, rsN_data SHALL equal wr_data in the same cycle; otherwise rsN_data = regs[rsN_addr].
- REQ-021: Both read ports SHALL be independent; the same address on both ports returns identical data.
- REQ-022: Scoreboard: busy[issue_rd] SHALL be set on an edge with issue_en=1 and issue_rd!=0.
- REQ-023: Scoreboard: busy[wr_addr] SHALL clear on an edge with wr_en=1, unless that same edge also sets it.
- REQ-024: Simultaneous issue and write to the same nonzero index SHALL leave busy=1, because the new producer wins.
- REQ-025: rsN_busy SHALL be busy[rsN_addr] AND NOT (wr_en AND wr_addr==rsN_addr); a same-cycle write-back hides busy because the data is bypassed.
- REQ-026: busy_count SHALL be registered and track the population of busy[] exactly, with the update visible one cycle after the edge.
- REQ-027: busy_count SHALL change by +1 (set only), -1 (clear only), 0 (set and clear on different indices), or 0 (set of an already-busy index, or clear of an idle index).
- REQ-028: busy_count SHALL never exceed NREGS-1 and never go below 0.
- REQ-029: Issuing to an already-busy register SHALL keep it busy without changing busy_count.
- REQ-030: Writing a non-busy register SHALL update data without changing busy_count.

Reset
- REQ-031: While rst=1 at an edge, all regs[] SHALL clear to 0, all busy bits to 0, and busy_count to 0.
- REQ-032: While rst=1, wr_en and issue_en SHALL be ignored.
- REQ-033: rs1_data and rs2_data SHALL still reflect the bypass path combinationally while rst=1.
- REQ-034: Reset asserted mid-operation SHALL discard all pending busy state; the first edge after rst deasserts accepts writes and issues normally.

Verification
- REQ-035: Write x5=0xDEADBEEF, then read rs1=5, rs2=5 next cycle -> both 0xDEADBEEF, busy 0.
- REQ-036: Same cycle wr_en=1, wr_addr=7, wr_data=0x1234, rs1_addr=7 (x7 held 0) -> rs1_data=0x1234 combinationally, rs1_busy=0.
- REQ-037: Write x0=0xFFFFFFFF and issue_rd=0 -> reads of x0 return 0, busy_count stays 0.
- REQ-038: Issue x3 and x4 -> busy_count=2; write x3 -> busy_count=1; issue x4 and write x4 in the same cycle -> x4 busy, busy_count stays 1.
- REQ-039: Issue to x1..x31 on 31 edges -> busy_count=31 (NREGS-1); write x1..x31 one per cycle -> busy_count back to 0.
- REQ-040: With 3 registers busy and x9=0x55, assert rst for one edge -> busy_count=0, all rsN_busy=0, x9 reads 0.
